// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer.
// The master drives the requests; the slave (the timer) returns state and count.
interface countdown_timer_if #(
  parameter int unsigned WIDTH = 5
);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             periodic;
  logic             pause;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             paused;
  logic             done;
  logic [WIDTH-1:0] count;

  modport master (
    output start, load_val, periodic, pause, abort,
    input  ready, busy, paused, done, count
  );

  modport slave (
    input  start, load_val, periodic, pause, abort,
    output ready, busy, paused, done, count
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot/periodic modes, pause and abort.
// Emits a one-cycle done pulse on the edge where a running count leaves 1.
module countdown_timer #(
  parameter int unsigned WIDTH = 5
) (
  input logic               clk,
  input logic               rst,
  countdown_timer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             start_ok;

  assign start_ok = bus.start && (bus.load_val != '0);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    if (bus.abort) begin
      state_d = StIdle;
      count_d = '0;
    end else if (start_ok) begin
      state_d  = StRun;
      count_d  = bus.load_val;
      reload_d = bus.load_val;
      mode_d   = bus.periodic;
    end else if (state_q != StIdle) begin
      if (bus.pause) begin
        state_d = StHold;
      end else if (count_q > WIDTH'(1)) begin
        state_d = StRun;
        count_d = count_q - WIDTH'(1);
      end else begin
        // Terminal count: reload in periodic mode, otherwise return to idle.
        done_d = 1'b1;
        if (mode_q) begin
          state_d = StRun;
          count_d = reload_q;
        end else begin
          state_d = StIdle;
          count_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
    end
  end

  assign bus.ready  = (state_q == StIdle);
  assign bus.busy   = (state_q == StRun) || (state_q == StHold);
  assign bus.paused = (state_q == StHold);
  assign bus.done   = done_q;
  assign bus.count  = count_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: per-cycle model comparison plus
// directed scenarios with hand-computed values, and a WIDTH=8 latency run.
module tb_countdown_timer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  countdown_timer_if #(.WIDTH(5)) bus ();
  countdown_timer_if #(.WIDTH(8)) bus8 ();

  countdown_timer #(.WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  countdown_timer #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Reference model: timer is "active" while counting, "held" while paused.
  int m_count  = 0;
  int m_reload = 0;
  bit m_per    = 1'b0;
  bit m_active = 1'b0;
  bit m_held   = 1'b0;
  bit m_done   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_count = 0; m_reload = 0; m_per = 0; m_active = 0; m_held = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (bus.abort) begin
        m_active = 0; m_held = 0; m_count = 0;
      end else if (bus.start && bus.load_val != 0) begin
        m_count = int'(bus.load_val); m_reload = m_count; m_per = bus.periodic;
        m_active = 1; m_held = 0;
      end else if (m_active) begin
        if (bus.pause) begin
          m_held = 1;
        end else if (m_count == 1) begin
          m_done = 1;
          m_held = 0;
          if (m_per) m_count = m_reload;
          else begin
            m_count = 0; m_active = 0;
          end
        end else begin
          m_count = (m_count - 1) % 32;
          m_held = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checks++;
      if (bus.ready !== !m_active || bus.busy !== m_active || bus.paused !== m_held ||
          bus.done !== m_done || int'(bus.count) != m_count) begin
        errors++;
        $display("FAIL model t=%0t got r%b b%b p%b d%b c%0d exp r%b b%b p%b d%b c%0d",
                 $time, bus.ready, bus.busy, bus.paused, bus.done, bus.count,
                 !m_active, m_active, m_held, m_done, m_count);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic start_run(input int val, input bit per);
    bus.start = 1'b1; bus.load_val = 5'(val); bus.periodic = per;
    tick();
    bus.start = 1'b0; bus.load_val = '0; bus.periodic = 1'b0;
  endtask

  initial begin
    int n;
    bus.start = 0; bus.load_val = '0; bus.periodic = 0; bus.pause = 0; bus.abort = 0;
    bus8.start = 0; bus8.load_val = '0; bus8.periodic = 0; bus8.pause = 0; bus8.abort = 0;

    rst = 1'b1;
    tick();
    tick();
    check_en = 1'b1;
    check_lit("rst_ready", int'(bus.ready), 1);
    check_lit("rst_busy", int'(bus.busy), 0);
    check_lit("rst_paused", int'(bus.paused), 0);
    check_lit("rst_done", int'(bus.done), 0);
    check_lit("rst_count", int'(bus.count), 0);
    rst = 1'b0;
    tick();

    // One-shot, load 8.
    start_run(8, 0);
    check_lit("os_first", int'(bus.count), 8);
    for (int i = 7; i >= 1; i--) begin
      tick();
      check_lit("os_count", int'(bus.count), i);
    end
    tick();
    check_lit("os_done", int'(bus.done), 1);
    check_lit("os_done_count", int'(bus.count), 0);
    check_lit("os_done_ready", int'(bus.ready), 1);
    tick();
    check_lit("os_done_once", int'(bus.done), 0);

    // Periodic, load 3, abort at count 2.
    start_run(3, 1);
    tick(); tick();
    check_lit("per_one", int'(bus.count), 1);
    tick();
    check_lit("per_done1", int'(bus.done), 1);
    check_lit("per_reload", int'(bus.count), 3);
    tick(); tick(); tick();
    check_lit("per_done2", int'(bus.done), 1);
    tick();
    check_lit("per_at2", int'(bus.count), 2);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_lit("abort_count", int'(bus.count), 0);
    check_lit("abort_ready", int'(bus.ready), 1);
    check_lit("abort_done", int'(bus.done), 0);
    tick();
    check_lit("abort_nodone", int'(bus.done), 0);

    // Pause for 4 cycles at count 3.
    start_run(5, 0);
    tick(); tick();
    bus.pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_lit("pause_paused", int'(bus.paused), 1);
      check_lit("pause_count", int'(bus.count), 3);
    end
    bus.pause = 1'b0;
    tick(); tick();
    check_lit("pause_pre", int'(bus.done), 0);
    tick();
    check_lit("pause_done", int'(bus.done), 1);

    // Pause at count 1 holds the terminal event.
    start_run(2, 0);
    tick();
    bus.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_lit("hold1_count", int'(bus.count), 1);
      check_lit("hold1_done", int'(bus.done), 0);
    end
    bus.pause = 1'b0;
    tick();
    check_lit("hold1_release", int'(bus.done), 1);

    // Restart on the terminal cycle suppresses done.
    start_run(4, 0);
    tick(); tick(); tick();
    check_lit("col_at1", int'(bus.count), 1);
    start_run(2, 0);
    check_lit("col_nodone", int'(bus.done), 0);
    check_lit("col_count", int'(bus.count), 2);
    tick();
    tick();
    check_lit("col_done", int'(bus.done), 1);

    // start with load_val 0 is ignored.
    start_run(0, 1);
    check_lit("zero_ready", int'(bus.ready), 1);
    check_lit("zero_count", int'(bus.count), 0);

    // Reset mid-count, then start on the first edge after reset.
    start_run(8, 0);
    tick(); tick();
    check_lit("mid_at6", int'(bus.count), 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_lit("mid_count", int'(bus.count), 0);
    check_lit("mid_ready", int'(bus.ready), 1);
    check_lit("mid_done", int'(bus.done), 0);
    start_run(31, 1);
    check_lit("post_rst_start", int'(bus.count), 31);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;

    // WIDTH=8, load 255: done 255 edges after the start edge.
    bus8.start = 1'b1; bus8.load_val = 8'd255;
    tick();
    bus8.start = 1'b0; bus8.load_val = '0;
    check_lit("w8_first", int'(bus8.count), 255);
    n = 0;
    while (n < 300 && bus8.done !== 1'b1) begin
      tick();
      n++;
    end
    check_lit("w8_latency", n, 255);
    check_lit("w8_ready", int'(bus8.ready), 1);

    tick();
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
